// File: rtl/cdce_readback_if.sv
// Pin-level bundle between the CDCE readback engine and its surroundings:
// request side (start/reg_addr/result/status) plus the SPI pins.
interface cdce_readback_if;
    logic        start;
    logic [3:0]  reg_addr;
    logic        miso;
    logic        cs_n;
    logic        mosi;
    logic        busy;
    logic [31:0] read_data;
    logic        read_valid;
    logic        addr_error;

    modport master (
        output start, reg_addr, miso,
        input  cs_n, mosi, busy, read_data, read_valid, addr_error
    );

    modport slave (
        input  start, reg_addr, miso,
        output cs_n, mosi, busy, read_data, read_valid, addr_error
    );
endinterface

// File: rtl/cdce_readback.sv
// CDCE register readback engine: a 32-bit read command frame, a chip-select
// gap, then a 32-bit capture frame on miso. One SPI bit per clk_i cycle.
//
// state | meaning
// IDLE  | cs_n high, waiting for start
// CMD   | shifting command word out on mosi, LSB first
// GAP1  | cs_n high between command and readback frames
// READ  | shifting miso into the capture register, LSB first
// GAP2  | cs_n high after readback; result published on entry
module cdce_readback #(
    parameter int CS_GAP  = 4,
    parameter int MAX_REG = 8
) (
    input logic              clk_i,
    input logic              reset_i,
    cdce_readback_if.slave   bus_if
);

    typedef enum logic [2:0] {IDLE, CMD, GAP1, READ, GAP2} state_t;

    localparam logic [3:0] MAX_ADDR = 4'(MAX_REG);
    localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);
    localparam logic [5:0] BIT_LOAD = 6'd31;

    state_t      state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [31:0] cmd_q, cmd_d;
    logic [31:0] cap_q, cap_d;
    logic [31:0] read_data_q, read_data_d;
    logic        read_valid_q, read_valid_d;
    logic        addr_error_q, addr_error_d;
    logic        cs_n_q, cs_n_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;

    // Next-state, down-counter and next-output logic; outputs derive from
    // the next state so every pin is driven straight from a flop.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        cmd_d        = cmd_q;
        cap_d        = cap_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        addr_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus_if.start) begin
                    if (bus_if.reg_addr <= MAX_ADDR) begin
                        cmd_d     = {24'h000000, bus_if.reg_addr, 4'hE};
                        bit_cnt_d = BIT_LOAD;
                        state_d   = CMD;
                    end else begin
                        addr_error_d = 1'b1;
                    end
                end
            end
            CMD: begin
                cmd_d = {1'b0, cmd_q[31:1]};
                if (bit_cnt_q == 6'd0) begin
                    gap_cnt_d = GAP_LOAD;
                    state_d   = GAP1;
                end else begin
                    bit_cnt_d = bit_cnt_q - 6'd1;
                end
            end
            GAP1: begin
                if (gap_cnt_q == 8'd0) begin
                    bit_cnt_d = BIT_LOAD;
                    state_d   = READ;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            READ: begin
                cap_d = {bus_if.miso, cap_q[31:1]};
                if (bit_cnt_q == 6'd0) begin
                    read_data_d  = cap_d;
                    read_valid_d = 1'b1;
                    gap_cnt_d    = GAP_LOAD;
                    state_d      = GAP2;
                end else begin
                    bit_cnt_d = bit_cnt_q - 6'd1;
                end
            end
            GAP2: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        cs_n_d = !((state_d == CMD) || (state_d == READ));
        busy_d = (state_d != IDLE);
        mosi_d = (state_d == CMD) ? cmd_d[0] : 1'b0;
    end

    // State, counters, shift registers and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 6'd0;
            gap_cnt_q    <= 8'd0;
            cmd_q        <= 32'h0;
            cap_q        <= 32'h0;
            read_data_q  <= 32'h0;
            read_valid_q <= 1'b0;
            addr_error_q <= 1'b0;
            cs_n_q       <= 1'b1;
            mosi_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            cmd_q        <= cmd_d;
            cap_q        <= cap_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            addr_error_q <= addr_error_d;
            cs_n_q       <= cs_n_d;
            mosi_q       <= mosi_d;
            busy_q       <= busy_d;
        end
    end

    assign bus_if.cs_n       = cs_n_q;
    assign bus_if.mosi       = mosi_q;
    assign bus_if.busy       = busy_q;
    assign bus_if.read_data  = read_data_q;
    assign bus_if.read_valid = read_valid_q;
    assign bus_if.addr_error = addr_error_q;

endmodule
